fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the single-register program counter and its combinational instruction-address path.
- Issues in-order requests to instruction memory with a valid/ready handshake.
- Buffers returned words with their PC in a DEPTH-entry prefetch queue.
- Presents them to decode with a valid/ready handshake.
- Flushes the queue and discards in-flight responses when a branch or jump redirect is taken.

Parameters:
XLEN, 32, data/address width.
DEPTH, 4, prefetch queue entries; power of 2, at least 2.
MAX_OUTSTANDING, 2, maximum unanswered memory requests; at least 1.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req_valid  out  1  request valid.
imem_req_ready  in  1  memory accepts the request this cycle.
imem_req_addr  out  XLEN  word-aligned fetch address.
imem_rsp_valid  in  1  response valid; in order, cannot be back-pressured.
imem_rsp_data  in  32  instruction word.
redirect_valid  in  1  taken branch/jump from stage 2.
redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored.
instr_valid  out  1  queue head valid.
instr_ready  in  1  decode consumes head.
instr_data  out  32  head instruction.
instr_pc  out  XLEN  head PC.
instr_pc_plus4  out  XLEN  head PC + 4, for the JAL/JALR link value.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc = RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - All outputs 0 except imem_req_addr=RESET_PC.
  - Instruction memory shares rst.
- imem_req_addr = fetch_pc.
- imem_req_valid = !redirect_valid && (count + live_outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - live_outstanding = outstanding - drop_cnt.
  - This credit scheme guarantees every kept response has a free slot. Overflow is impossible and is asserted against.
- Request handshake (valid && ready): fetch_pc += 4 with modulo 2^XLEN wrap; outstanding++.
- Response with drop_cnt>0: discarded; drop_cnt--; outstanding--.
- Response with drop_cnt=0: enqueue {imem_rsp_data, pc} with pc from an internal PC FIFO of depth MAX_OUTSTANDING; outstanding--.
- Simultaneous request and response: outstanding unchanged.
- Dequeue on instr_valid && instr_ready.
  - Simultaneous enqueue and dequeue is legal at any count, including full.
  - Read-first: head shows the old entry.
- instr_valid = (count != 0); driven from registers only, no combinational path from any input.
- Latency: request accepted in cycle N with a same-cycle response gives instr_valid in N+1. Best-case throughput is 1 instruction/cycle.
- Redirect (redirect_valid=1) has priority over everything:
  - queue count := 0; any dequeue that cycle is ignored.
  - fetch_pc := {redirect_pc[XLEN-1:2], 2'b00}.
  - No request issued that cycle.
  - drop_cnt := outstanding - (imem_rsp_valid ? 1 : 0); a response in the redirect cycle itself is discarded.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Empty queue with instr_ready=1: no effect.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output perf_stall_cycles (32 bits), counting cycles with instr_ready=1 and instr_valid=0.
  - Adds output perf_flushed (32 bits), counting entries discarded from the queue plus dropped responses.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; otherwise identical behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_entry_t typedef {instr[31:0], pc[XLEN-1:0]}.
  - localparam INSTR_BYTES=4.
  - The opcode constants for JAL/JALR/BRANCH already used by the core.
- One sub-module: fetch_fifo, parametrised synchronous FIFO (DEPTH, entry type) with count output. It is instantiated for both the main queue and the PC-tracking FIFO.

Test Plan:
1. Reset then always-ready memory with same-cycle responses, instr_ready=1 → instr_pc sequence 0x0, 0x4, 0x8, … one per cycle from cycle 1.
2. instr_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued; imem_req_valid=0 afterwards; queue holds PCs 0x0–0xC.
3. MAX_OUTSTANDING=2, 2 requests pending, redirect to 0x100 → both late responses dropped; next instr_pc=0x100 with the response to address 0x100.
4. Redirect in the same cycle as a response arrives, and redirect_pc=0x203 → that response dropped; next fetch address 0x200.
5. Assert rst mid-stream with a full queue → all outputs zero immediately (asynchronous); after release, fetch restarts at RESET_PC.
6. FETCH_PERF_CNT_EN defined: memory stalls 5 cycles with instr_ready=1 → perf_stall_cycles=5; a redirect with 3 queued entries → perf_flushed=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch queue entry layout, instruction size and control-flow opcodes.
package cpu_pkg;

  localparam int CPU_XLEN    = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0]         instr;
    logic [CPU_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count. Pop is read-first, so a push and a pop
// in the same cycle are legal even when the FIFO is full.
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop, full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries data only; occupancy is tracked by the control registers above.
  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (!rst && !flush) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/fetch_queue.sv
// RV32 instruction-fetch front end: credit-limited memory requests, prefetch queue, redirect flush.
// Define FETCH_PERF_CNT_EN to add the perf_stall_cycles / perf_flushed counters.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            CLK,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flushed
`endif
);
  localparam int QCW = $clog2(DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;

  logic [XLEN-1:0] fetch_pc, pcf_head, rsp_pc;
  logic [OCW-1:0]  outstanding, drop_cnt, live;
  logic [QCW-1:0]  q_count;
  logic [31:0]     credit;
  logic            req_fire, rsp_bypass, rsp_keep, pcf_push, pcf_pop, q_pop;
  fetch_entry_t    q_in, q_head;

  // Requests still expected to land in the queue reserve a slot before they are issued.
  assign live           = outstanding - drop_cnt;
  assign credit         = 32'(q_count) + 32'(live);
  assign imem_req_valid = !rst && !redirect_valid && (credit < 32'(DEPTH))
                          && (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding answers the request issued this very cycle.
  assign rsp_bypass = imem_rsp_valid && (outstanding == '0);
  assign rsp_pc     = rsp_bypass ? fetch_pc : pcf_head;
  assign pcf_push   = req_fire && !rsp_bypass;
  assign pcf_pop    = imem_rsp_valid && !rsp_bypass;
  assign rsp_keep   = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign q_in       = '{instr: imem_rsp_data, pc: rsp_pc};
  assign q_pop      = instr_ready && !redirect_valid;

  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .entry_t(logic [XLEN-1:0])) u_pc_fifo (
    .CLK       (CLK),
    .rst       (rst),
    .flush     (1'b0),
    .push      (pcf_push),
    .push_data (fetch_pc),
    .pop       (pcf_pop),
    .pop_data  (pcf_head),
    .count     (outstanding)
  );

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_queue (
    .CLK       (CLK),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (q_in),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (q_count)
  );

  assign instr_valid    = (q_count != '0);
  assign instr_data     = instr_valid ? q_head.instr : '0;
  assign instr_pc       = instr_valid ? q_head.pc : '0;
  assign instr_pc_plus4 = instr_valid ? q_head.pc + XLEN'(INSTR_BYTES) : '0;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= outstanding - OCW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  logic        rsp_drop;
  logic [31:0] flush_amt;

  assign rsp_drop  = imem_rsp_valid && (drop_cnt != '0);
  assign flush_amt = redirect_valid ? 32'(q_count) + 32'(imem_rsp_valid) : 32'(rsp_drop);

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushed      <= '0;
    end else begin
      perf_stall_cycles <= sat_add(perf_stall_cycles, 32'(instr_ready && !instr_valid));
      perf_flushed      <= sat_add(perf_flushed, flush_amt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against an epoch-tagged model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc, instr_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushed;
`endif

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .CLK            (CLK),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushed      (perf_flushed)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: lat==0 answers in the request cycle, otherwise after lat cycles.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mem_pend[$];
  int          lat;
  int          cyc;
  logic        mem_vld;
  logic [31:0] mem_dat;

  assign imem_rsp_valid = (lat == 0) ? (imem_req_valid && imem_req_ready) : mem_vld;
  assign imem_rsp_data  = (lat == 0) ? word_at(imem_req_addr) : mem_dat;

  always @(posedge CLK or posedge rst) begin
    if (rst) begin
      mem_pend.delete();
      mem_vld <= 1'b0;
      mem_dat <= '0;
      cyc     <= 0;
    end else begin
      if (lat != 0) begin
        if (mem_vld) void'(mem_pend.pop_front());
        if (imem_req_valid && imem_req_ready) mem_pend.push_back('{imem_req_addr, cyc + lat});
        if (mem_pend.size() != 0) begin
          mem_vld <= (mem_pend[0].due <= cyc + 1);
          mem_dat <= word_at(mem_pend[0].addr);
        end else begin
          mem_vld <= 1'b0;
        end
      end
      cyc <= cyc + 1;
    end
  end

  // Reference model: requests tagged with the redirect epoch they were issued in.
  typedef struct { logic [31:0] addr; int ep; } preq_t;
  preq_t       pend[$];
  logic [31:0] q_pc[$];
  int          epoch;
  logic [31:0] fpc;
  int          stall_m, flushed_m;
  int          nfire;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy, input logic mrdy);
    logic  fire, rsp, exp_req, keep;
    int    live;
    preq_t e;
    @(negedge CLK);
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    imem_req_ready = mrdy;
    #1;
    live = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) live++;
    exp_req = !rv && (q_pc.size() + live < DEPTH) && (pend.size() < MAXO);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    chk("req_addr", imem_req_addr, fpc);
    chk("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      chk("instr_pc", instr_pc, q_pc[0]);
      chk("instr_data", instr_data, word_at(q_pc[0]));
      chk("instr_pc_plus4", instr_pc_plus4, q_pc[0] + 32'd4);
    end
    fire = imem_req_valid && imem_req_ready;
    rsp  = imem_rsp_valid;
    if (rdy && q_pc.size() == 0) stall_m++;
    @(posedge CLK);
    if (fire) begin
      pend.push_back('{fpc, epoch});
      nfire++;
    end
    keep = 1'b0;
    if (rsp && pend.size() != 0) begin
      e    = pend.pop_front();
      keep = !rv && (e.ep == epoch);
      if (!rv && !keep) flushed_m++;
    end
    if (!rv && rdy && q_pc.size() != 0) void'(q_pc.pop_front());
    if (keep) q_pc.push_back(e.addr);
    if (rv) begin
      flushed_m += q_pc.size() + (rsp ? 1 : 0);
      q_pc.delete();
      epoch++;
      fpc = {rpc[31:2], 2'b00};
    end else if (fire) begin
      fpc = fpc + 32'd4;
    end
  endtask

  task automatic do_reset(input int new_lat);
    @(negedge CLK);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, 32'(stall_m));
    chk("perf_flushed", perf_flushed, 32'(flushed_m));
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_pc4", instr_pc_plus4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
    lat            = new_lat;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    pend.delete();
    q_pc.delete();
    epoch     = 0;
    fpc       = 32'h0;
    stall_m   = 0;
    flushed_m = 0;
    @(negedge CLK);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    total = 0; bad = 0; nfire = 0; lat = 0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0; imem_req_ready = 1'b0;

    // Streaming with same-cycle responses: one instruction per cycle.
    do_reset(0);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Decode stalled: exactly DEPTH requests, then the queue is full.
    do_reset(0);
    n0 = nfire;
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("fill_reqs", 32'(nfire - n0), 32'(DEPTH));
    #1;
    chk("full_head_pc", instr_pc, 32'h0);

    // Reset mid-stream with a full queue, then two pending requests redirected to 0x100.
    do_reset(2);
    repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h100, 1'b0, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("redir_head_pc", instr_pc, 32'h100);
    chk("redir_head_data", instr_data, word_at(32'h100));

    // Redirect coinciding with a response, unaligned target.
    do_reset(1);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h203, 1'b1, 1'b1);
    #1;
    chk("redir_align", imem_req_addr, 32'h200);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Randomized traffic at each memory latency.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(seg);
      for (int k = 0; k < 300; k++)
        step($urandom_range(0, 99) < 6, $urandom & 32'h0000_0FFF,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    do_reset(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
